clk_period_meter: RTL

//  Measures an asynchronous slow periodic input (divided clock, PWM, encoder

---
 rtl/clk_period_meter.sv | 112 +++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous input in system-clock
// cycles, with a one-cycle update strobe, a lock flag and a saturating timeout.
module clk_period_meter #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic                   meas_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic [COUNT_WIDTH-1:0] hi_reg;
    logic                   have_prev;

    // NOTE: the synchroniser is cleared by rst as well, so no stale edge
    // left in the chain can be detected after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Never wraps: cnt_inc is only used while cnt is below CNT_MAX.
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_reg     <= '0;
            have_prev  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        cnt    <= '0;
                        hi_reg <= '0;
                        state  <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (cnt == CNT_MAX) begin
                        // Saturated: a rise arriving this cycle is discarded.
                        state     <= ST_TIMEOUT;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        have_prev <= 1'b0;
                    end else if (rise) begin
                        period     <= cnt_inc;
                        high_time  <= hi_reg;
                        meas_valid <= 1'b1;
                        locked     <= have_prev && (cnt_inc == period);
                        have_prev  <= 1'b1;
                        cnt        <= '0;
                        hi_reg     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (fall) begin
                            hi_reg <= cnt_inc;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    if (rise) begin
                        timeout <= 1'b0;
                        cnt     <= '0;
                        hi_reg  <= '0;
                        state   <= ST_MEASURE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
